// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared types and constants for the multi-cycle divider and its EX-stage handshake.
package div_unit_pkg;

    typedef logic [1:0] div_state_t;

    localparam div_state_t DIV_IDLE = 2'd0;
    localparam div_state_t DIV_ZERO = 2'd1;
    localparam div_state_t DIV_ON   = 2'd2;
    localparam div_state_t DIV_END  = 2'd3;

    localparam logic DIV_START     = 1'b1;
    localparam logic DIV_STOP      = 1'b0;
    localparam logic DIV_READY     = 1'b1;
    localparam logic DIV_NOT_READY = 1'b0;

    // decode_table funct codes for the two divide flavours
    localparam logic [5:0] DIV_OP  = 6'b011010;
    localparam logic [5:0] DIVU_OP = 6'b011011;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration; trial subtract of the divisor, then shift in a quotient bit.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] work,
    input  logic [DATA_W-1:0]   dvs,
    output logic [2*DATA_W:0]   next_work
);

    logic [DATA_W:0] diff;

    always_comb begin
        diff      = {1'b0, work[2*DATA_W-1:DATA_W]} - {1'b0, dvs};
        next_work = diff[DATA_W] ? {work, 1'b0} : {diff[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring divider answering EX DIV/DIVU requests with {hi=remainder, lo=quotient}.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  div_start_i,
    input  logic                  div_signed_i,
    input  logic [DATA_W-1:0]     div_oprd1_i,
    input  logic [DATA_W-1:0]     div_oprd2_i,
    input  logic                  div_annul_i,
    output logic [2*DATA_W-1:0]   div_result_o,
    output logic                  div_ready_o
);

    localparam int CW = $clog2(DATA_W);

    div_state_t          state;
    logic [CW-1:0]       cnt;
    logic [2*DATA_W:0]   work;
    logic [2*DATA_W:0]   next_work;
    logic [DATA_W-1:0]   dvs;
    logic                neg_a;
    logic                neg_b;
    logic [2*DATA_W-1:0] res;
    logic [DATA_W-1:0]   abs_a;
    logic [DATA_W-1:0]   abs_b;
    logic [DATA_W-1:0]   fix_q;
    logic [DATA_W-1:0]   fix_r;

    always_comb begin
        abs_a = (div_signed_i && div_oprd1_i[DATA_W-1]) ? -div_oprd1_i : div_oprd1_i;
        abs_b = (div_signed_i && div_oprd2_i[DATA_W-1]) ? -div_oprd2_i : div_oprd2_i;
        fix_q = (neg_a ^ neg_b) ? -next_work[DATA_W-1:0] : next_work[DATA_W-1:0];
        fix_r = neg_a ? -next_work[2*DATA_W:DATA_W+1] : next_work[2*DATA_W:DATA_W+1];
    end

    div_step #(.DATA_W(DATA_W)) u_step (
        .work      (work[2*DATA_W-1:0]),
        .dvs       (dvs),
        .next_work (next_work)
    );

    // ready/result are registered one edge after entering END, so EX sees them only while it still holds start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= DIV_IDLE;
            cnt          <= '0;
            work         <= '0;
            dvs          <= '0;
            neg_a        <= 1'b0;
            neg_b        <= 1'b0;
            res          <= '0;
            div_result_o <= '0;
            div_ready_o  <= DIV_NOT_READY;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (div_start_i == DIV_START && !div_annul_i) begin
                        neg_a <= div_signed_i & div_oprd1_i[DATA_W-1];
                        neg_b <= div_signed_i & div_oprd2_i[DATA_W-1];
                        dvs   <= abs_b;
                        cnt   <= '0;
                        work  <= {{DATA_W{1'b0}}, abs_a, 1'b0};
                        state <= (div_oprd2_i == '0) ? DIV_ZERO : DIV_ON;
                    end
                end
                DIV_ZERO: begin
                    res   <= '0;
                    state <= div_annul_i ? DIV_IDLE : DIV_END;
                end
                DIV_ON: begin
                    if (div_annul_i) begin
                        state <= DIV_IDLE;
                    end else begin
                        work <= next_work;
                        cnt  <= cnt + 1'b1;
                        if (cnt == CW'(DATA_W - 1)) begin
                            res   <= {fix_r, fix_q};
                            state <= DIV_END;
                        end
                    end
                end
                DIV_END: begin
                    if (div_start_i == DIV_STOP || div_annul_i) begin
                        state        <= DIV_IDLE;
                        div_ready_o  <= DIV_NOT_READY;
                        div_result_o <= '0;
                    end else begin
                        div_ready_o  <= DIV_READY;
                        div_result_o <= res;
                    end
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed divide vectors; expectations queued at issue, checked by a monitor on each ready rise.
module tb_div_unit;
    import div_unit_pkg::*;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          t0;
        string       name;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e_m;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [63:0] result;
    logic        ready;
    logic        prev = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_start_i  (start),
        .div_signed_i (sgn),
        .div_oprd1_i  (a),
        .div_oprd2_i  (b),
        .div_annul_i  (annul),
        .div_result_o (result),
        .div_ready_o  (ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst && ready && !prev) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready with result %h, required no ready", result);
            end else begin
                e_m = sbq.pop_front();
                chk({e_m.name, "_result"}, result, e_m.res);
                chk({e_m.name, "_latency"}, 64'(cyc - e_m.t0), 64'(e_m.lat));
            end
        end
        prev <= ready;
    end

    task automatic issue(string name, logic s, logic [31:0] x, logic [31:0] y, logic [63:0] er, int lat);
        @(negedge clk);
        sgn   = s;
        a     = x;
        b     = y;
        start = 1'b1;
        sbq.push_back('{res: er, lat: lat, t0: cyc + 1, name: name});
    endtask

    task automatic wait_ready(string name);
        int n = 0;
        while (!ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: ready=0 after %0d cycles, required 1", name, n);
        end
    endtask

    task automatic finish_op(string name, logic [63:0] er);
        wait_ready(name);
        repeat (2) begin
            @(negedge clk);
            chk({name, "_held_ready"}, 64'(ready), 64'(1));
            chk({name, "_held_result"}, result, er);
        end
        start = 1'b0;
        @(negedge clk);
        chk({name, "_clear_ready"}, 64'(ready), 64'(0));
        chk({name, "_clear_result"}, result, 64'(0));
    endtask

    task automatic do_div(string name, logic s, logic [31:0] x, logic [31:0] y, logic [63:0] er, int lat);
        issue(name, s, x, y, er, lat);
        finish_op(name, er);
    endtask

    initial begin
        int t0;
        int seen;
        hilo_t h;
        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(ready), 64'(0));
        chk("reset_result", result, 64'(0));
        rst = 1'b1;

        do_div("u100_7",  1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 33);
        do_div("s_m7_2",  1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},   33);
        do_div("s_7_m2",  1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},          33);
        do_div("u_big_2", 1'b0, 32'hFFFFFFF9,   32'd2,          {32'd1, 32'h7FFFFFFC},          33);
        do_div("div0",    1'b0, 32'h12345678,   32'd0,          64'd0,                           2);
        do_div("u_max_1", 1'b0, 32'hFFFFFFFF,   32'd1,          {32'd0, 32'hFFFFFFFF},          33);
        h = '{hi: 32'd0, lo: 32'h80000000};
        do_div("s_ovf",   1'b1, 32'h80000000,   32'hFFFFFFFF,   h,                               33);

        // annul while the counter is at 10
        @(negedge clk);
        sgn = 1'b0; a = 32'd1000; b = 32'd7; start = 1'b1;
        t0 = cyc + 1;
        while (cyc < t0 + 10) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        start = 1'b0;
        annul = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) seen++;
        end
        chk("annul_no_ready", 64'(seen), 64'(0));

        // operands changing during ON must not disturb the result
        issue("after_annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);
        repeat (3) @(negedge clk);
        a = 32'hDEADBEEF;
        b = 32'd0;
        finish_op("after_annul", {32'd0, 32'd3});

        // asynchronous reset with the counter at 20
        @(negedge clk);
        sgn = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
        t0 = cyc + 1;
        while (cyc < t0 + 20) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_ready", 64'(ready), 64'(0));
        chk("rst_mid_result", result, 64'(0));
        issue("after_rst", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33);
        rst = 1'b1;
        finish_op("after_rst", {32'd0, 32'd10});

        // asynchronous reset while a result is being presented
        issue("rst_end", 1'b0, 32'd100, 32'd10, {32'd0, 32'd10}, 33);
        wait_ready("rst_end");
        #2 rst = 1'b0;
        #1;
        chk("rst_end_ready", 64'(ready), 64'(0));
        chk("rst_end_result", result, 64'(0));
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // annul in END drops the result even with start still held
        issue("annul_end", 1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33);
        wait_ready("annul_end");
        annul = 1'b1;
        @(negedge clk);
        chk("annul_end_ready", 64'(ready), 64'(0));
        chk("annul_end_result", result, 64'(0));
        start = 1'b0;
        annul = 1'b0;

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
